// File: rtl/dmem_access_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_access_unit_if : load/store request bus plus word-RAM port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_access_unit_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 12
);
   logic                      req;
   logic                      wr;
   logic [1:0]                size;
   logic                      is_signed;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [31:0]               wdata;
   logic                      busy;
   logic                      done;
   logic                      err;
   logic [31:0]               rdata;
   logic [RAM_ADDR_WIDTH-1:0] ram_a;
   logic [31:0]               ram_wd;
   logic                      ram_we;
   logic [31:0]               ram_rd;

   // master is the environment: the core plus the RAM behind the unit
   modport master (
      output req, wr, size, is_signed, addr, wdata, ram_rd,
      input  busy, done, err, rdata, ram_a, ram_wd, ram_we
   );

   modport slave (
      input  req, wr, size, is_signed, addr, wdata, ram_rd,
      output busy, done, err, rdata, ram_a, ram_wd, ram_we
   );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_access_unit : byte/half/word load-store to word RAM, RMW sub-word stores
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_access_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 12
) (
   input  wire logic         clk_i,
   input  wire logic         rst_i,
   dmem_access_unit_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam int         LA_W    = RAM_ADDR_WIDTH + 2;

   logic [1:0]      state_q, state_d;
   logic            wr_q, wr_d;
   logic [1:0]      size_q, size_d;
   logic            sgn_q, sgn_d;
   logic [LA_W-1:0] addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     word_q, word_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;

   logic            bad_w;
   logic [7:0]      byte_w;
   logic [15:0]     half_w;
   logic [31:0]     load_fmt_w;
   logic [31:0]     merge_w;
   logic            unused_addr_hi;

   assign unused_addr_hi = ^bus.addr[ADDR_WIDTH-1:LA_W];

   assign bad_w = (bus.size == 2'b11)
                | ((bus.size == 2'b01) & bus.addr[0])
                | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));

   // Load formatting works on the live RAM word since it is captured at the same edge
   always_comb begin
      byte_w = 8'h00;
      case (addr_q[1:0])
         2'd0:    byte_w = bus.ram_rd[7:0];
         2'd1:    byte_w = bus.ram_rd[15:8];
         2'd2:    byte_w = bus.ram_rd[23:16];
         default: byte_w = bus.ram_rd[31:24];
      endcase
      half_w = addr_q[1] ? bus.ram_rd[31:16] : bus.ram_rd[15:0];
      case (size_q)
         2'b00:   load_fmt_w = {{24{sgn_q & byte_w[7]}}, byte_w};
         2'b01:   load_fmt_w = {{16{sgn_q & half_w[15]}}, half_w};
         default: load_fmt_w = bus.ram_rd;
      endcase
   end

   always_comb begin
      merge_w = word_q;
      case (size_q)
         2'b00:   merge_w[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
         2'b01:   merge_w[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merge_w = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               wr_d    = bus.wr;
               size_d  = bus.size;
               sgn_d   = bus.is_signed;
               addr_d  = bus.addr[LA_W-1:0];
               wdata_d = bus.wdata;
               err_d   = bad_w;
               if (bad_w)
                  state_d = S_RESP;
               else if (bus.wr && (bus.size == 2'b10))
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ: begin
            word_d = bus.ram_rd;
            if (wr_q) begin
               state_d = S_WRITE;
            end else begin
               rdata_d = load_fmt_w;
               state_d = S_RESP;
            end
         end
         S_WRITE: state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_RESP);
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;
   assign bus.ram_a  = addr_q[LA_W-1:2];
   assign bus.ram_wd = merge_w;
   // Write strobe drops combinationally with reset so a reset in WRITE never commits
   assign bus.ram_we = (state_q == S_WRITE) & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_access_unit : directed self-checking bench with a behavioural word RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;
   logic clk;
   logic rst;
   logic init_mem;

   logic [31:0] mem [0:4095];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   int          lat;
   int          we_n;
   int          we_cyc;
   logic [31:0] wd_seen;
   logic [31:0] a_seen;
   logic [31:0] err_seen;
   int          busy_cnt;
   int          done_cnt;

   dmem_access_unit_if #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(12)) bus ();

   dmem_access_unit #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(12)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.ram_rd = mem[bus.ram_a];

   always @(posedge clk) begin
      if (init_mem) begin
         mem[0] <= 32'h11223344;
         mem[1] <= 32'h8899AABB;
         mem[2] <= 32'h00000000;
      end else if (bus.ram_we) begin
         mem[bus.ram_a] <= bus.ram_wd;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // Issue one request in an IDLE cycle and watch up to 8 cycles for DONE
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.is_signed = sg;
      bus.addr = a; bus.wdata = d;
      @(posedge clk); #1;
      bus.req = 1'b0;
      lat = 0; we_n = 0; we_cyc = 0; wd_seen = 32'h0; a_seen = 32'h0; err_seen = 32'h0;
      for (int k = 1; k <= 8; k++) begin
         if (bus.ram_we) begin
            we_n++; we_cyc = k; wd_seen = bus.ram_wd; a_seen = 32'(bus.ram_a);
         end
         if (bus.done) begin
            lat = k; err_seen = 32'(bus.err);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; init_mem = 1'b1;
      bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.is_signed = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  32'(bus.busy),   32'h0);
      check("rst_done",  32'(bus.done),   32'h0);
      check("rst_err",   32'(bus.err),    32'h0);
      check("rst_we",    32'(bus.ram_we), 32'h0);
      check("rst_rdata", bus.rdata,       32'h0);
      init_mem = 1'b0; rst = 1'b0;

      do_req(1'b0, 2'b00, 1'b1, 32'd5, 32'h0);
      check("lb5_rdata", bus.rdata, 32'hFFFFFFAA);
      check("lb5_lat",   32'(lat),  32'd2);
      check("lb5_err",   err_seen,  32'h0);

      do_req(1'b0, 2'b00, 1'b0, 32'd7, 32'h0);
      check("lbu7_rdata", bus.rdata, 32'h00000088);

      do_req(1'b0, 2'b01, 1'b1, 32'd6, 32'h0);
      check("lh6_rdata", bus.rdata, 32'hFFFF8899);

      do_req(1'b0, 2'b01, 1'b0, 32'd4, 32'h0);
      check("lhu4_rdata", bus.rdata, 32'h0000AABB);

      do_req(1'b1, 2'b00, 1'b0, 32'd4, 32'hFFFFFF12);
      check("sb4_lat",   32'(lat),    32'd3);
      check("sb4_wecyc", 32'(we_cyc), 32'd2);
      check("sb4_wen",   32'(we_n),   32'd1);
      check("sb4_wd",    wd_seen,     32'h8899AA12);
      check("sb4_rdata", bus.rdata,   32'h0000AABB);

      do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
      check("lw4_rdata", bus.rdata, 32'h8899AA12);
      check("lw4_lat",   32'(lat),  32'd2);

      do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
      check("sw8_lat",   32'(lat),    32'd2);
      check("sw8_wecyc", 32'(we_cyc), 32'd1);
      check("sw8_a",     a_seen,      32'd2);
      check("sw8_mem",   mem[2],      32'hDEADBEEF);
      check("sw8_rdata", bus.rdata,   32'h8899AA12);

      do_req(1'b1, 2'b01, 1'b0, 32'd6, 32'h00005566);
      check("sh6_lat", 32'(lat), 32'd3);
      check("sh6_mem", mem[1],   32'h5566AA12);

      do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
      check("lw4b_rdata", bus.rdata, 32'h5566AA12);

      do_req(1'b1, 2'b10, 1'b0, 32'd3, 32'h12345678);
      check("sw3_lat",   32'(lat),  32'd1);
      check("sw3_err",   err_seen,  32'h1);
      check("sw3_wen",   32'(we_n), 32'd0);
      check("sw3_rdata", bus.rdata, 32'h5566AA12);
      check("sw3_errhold", 32'(bus.err), 32'h1);

      do_req(1'b0, 2'b01, 1'b1, 32'd1, 32'h0);
      check("lh1_lat",   32'(lat),  32'd1);
      check("lh1_err",   err_seen,  32'h1);
      check("lh1_rdata", bus.rdata, 32'h5566AA12);

      do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
      check("sz3_lat",   32'(lat),  32'd1);
      check("sz3_err",   err_seen,  32'h1);
      check("sz3_wen",   32'(we_n), 32'd0);
      check("sz3_rdata", bus.rdata, 32'h5566AA12);

      // Continuous REQ: accepts only from IDLE, so BUSY,BUSY,IDLE repeats
      @(negedge clk);
      bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b10; bus.is_signed = 1'b0; bus.addr = 32'd0;
      busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         busy_cnt += int'(bus.busy);
         done_cnt += int'(bus.done);
      end
      bus.req = 1'b0;
      check("hold_done", 32'(done_cnt), 32'd3);
      check("hold_busy", 32'(busy_cnt), 32'd6);
      check("hold_rdata", bus.rdata, 32'h11223344);
      check("hold_err", 32'(bus.err), 32'h0);

      // Reset landing in the WRITE cycle of a half store
      @(negedge clk);
      bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b01; bus.addr = 32'd0; bus.wdata = 32'h0000BEEF;
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      check("shr_we_pre", 32'(bus.ram_we), 32'h1);
      check("shr_wd",     bus.ram_wd,      32'h1122BEEF);
      rst = 1'b1;
      #1;
      check("shr_we_gate", 32'(bus.ram_we), 32'h0);
      @(posedge clk); #1;
      check("shr_busy",  32'(bus.busy), 32'h0);
      check("shr_done",  32'(bus.done), 32'h0);
      check("shr_rdata", bus.rdata,     32'h0);
      check("shr_mem",   mem[0],        32'h11223344);
      rst = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sits between the core's load/store stage and the word-organised data RAM: the single-port RAM with asynchronous read, synchronous write and ports A/WD/WE/RD.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Sub-word stores are done as read-modify-write.
- Checks alignment and returns sign/zero-extended load data under a REQ/DONE handshake.

Parameters:
- ADDR_WIDTH, 32: width of core byte address ADDR.
- RAM_ADDR_WIDTH, 12: RAM word-address width (4096 words).
- DATA_WIDTH: fixed at 32; byte-lane logic assumes 4 lanes.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- REQ  in  1  request; sampled only in IDLE.
- WR  in  1  1 = store, 0 = load.
- SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved.
- SIGNED  in  1  sign-extend sub-word loads.
- ADDR  in  ADDR_WIDTH  byte address.
- WDATA  in  32  store data, right-aligned.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  misaligned or reserved SIZE; valid with DONE.
- RDATA  out  32  formatted load data.
- RAM_A  out  RAM_ADDR_WIDTH  word address to RAM.
- RAM_WD  out  32  write data to RAM.
- RAM_WE  out  1  write enable to RAM.
- RAM_RD  in  32  read data from RAM (combinational).

Behaviour:
- Byte order is little-endian: byte offset 0 = bits 7:0.
- Word address = ADDR[RAM_ADDR_WIDTH+1:2]. Higher ADDR bits are ignored.
- Reset: state = IDLE; RDATA, ERR, DONE, RAM_WE = 0; latched address/data/control = 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE, with REQ = 1:
  - Latch WR, SIZE, SIGNED, ADDR, WDATA. Clear ERR.
  - Misaligned (half with ADDR[0] = 1; word with ADDR[1:0] != 0) or SIZE = 11: set err flag, go to RESP. The RAM is not touched.
  - Load: go to READ.
  - Word store: go to WRITE.
  - Sub-word store: go to READ.
- READ:
  - RAM_A = latched word address; RAM_WE = 0. Capture RAM_RD into an internal word register.
  - Load: format RDATA at this edge:
    - Select the lane by ADDR[1:0] (byte) or ADDR[1] (half).
    - Zero-extend, or sign-extend if SIGNED = 1. Word loads are passed unchanged.
    - Then go to RESP.
  - Sub-word store: go to WRITE.
- WRITE:
  - RAM_WE = 1 for exactly this one cycle.
  - RAM_WD = WDATA (word store), or the captured word with the addressed byte/half lane replaced by WDATA[7:0] / WDATA[15:0].
  - Then go to RESP.
- RESP:
  - DONE = 1 and ERR = err flag. Go to IDLE.
- Latency, with REQ accepted in cycle T:
  - Load: DONE in T+2.
  - Word store: DONE in T+2.
  - Sub-word store: DONE in T+3.
  - Error: DONE and ERR in T+1.
- Next REQ may be accepted in the cycle after DONE. There are no back-to-back accepts in the DONE cycle.
- REQ while BUSY is ignored and not queued. Inputs are don't-care after acceptance.
- RDATA holds its value until the next successful load completes. Stores and errors leave it unchanged.
- ERR holds until the next REQ is accepted.
- RAM_WE is gated by !RST: no RAM write occurs in any cycle with RST = 1, including a reset arriving during WRITE.
- RAM_A and RAM_WD are driven from latched registers in all states, so they are stable during BUSY.

Test Plan:
- Preload word addr 1 = 0x8899AABB.
  - LB ADDR = 5, SIGNED = 1 -> RDATA = 0xFFFFFFAA, DONE at T+2, ERR = 0.
  - LBU ADDR = 7 -> RDATA = 0x00000088.
  - LH ADDR = 6, SIGNED = 1 -> RDATA = 0xFFFF8899.
  - LHU ADDR = 4 -> RDATA = 0x0000AABB.
- SB ADDR = 4, WDATA = 0x12 -> RAM_WE high only at T+2, RAM_WD = 0x8899AA12, DONE at T+3. A following LW ADDR = 4 returns 0x8899AA12.
- SW ADDR = 8, WDATA = 0xDEADBEEF -> RAM_WE at T+1, RAM_A = 2, DONE at T+2. RDATA is unchanged.
- SW ADDR = 3 and LH ADDR = 1 -> DONE and ERR = 1 at T+1, RAM_WE never asserted, RDATA unchanged. SIZE = 11 -> same result.
- Hold REQ = 1 continuously with LW ADDR = 0 -> requests accepted only in IDLE: one access per 3 cycles, BUSY high between accepts.
- Assert RST in the WRITE cycle of an SH -> RAM contents unchanged. Next cycle: state = IDLE, BUSY = 0, DONE = 0, RDATA = 0.
